// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap/mret sequencer driving the csr exception write side
module trap_ctrl #(
    parameter logic [1:0] RESET_MPP = 2'b11
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] badaddr_i,
    input  logic        e_fetch_mis_i,
    input  logic        e_illegal_i,
    input  logic        e_ecall_i,
    input  logic        e_ebreak_i,
    input  logic        e_load_mis_i,
    input  logic        e_store_mis_i,
    input  logic        e_illegal_csr_i,
    input  logic        mret_i,
    input  logic        meip_i,
    input  logic        mtip_i,
    input  logic        msip_i,
    input  logic [31:0] mie_i,
    input  logic [31:0] exc_ret_addr_i,
    input  logic        csr_mstatus_we_i,
    input  logic [31:0] csr_mstatus_wdata_i,
    output logic        we_exc_o,
    output logic [31:0] mcause_o,
    output logic [31:0] mepc_o,
    output logic [31:0] mtval_o,
    output logic [31:0] mstatus_o,
    output logic [31:0] mip_o,
    output logic        sel_exc_nret_o,
    output logic        is_int_o,
    output logic        flush_o,
    output logic        busy_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o
);

    typedef enum logic [1:0] {IDLE, TRAP, REDIR, RET} state_t;

    state_t      state;
    logic        mie_q;
    logic        mpie_q;
    logic [1:0]  mpp_q;

    logic        meie_hit;
    logic        msie_hit;
    logic        mtie_hit;
    logic        int_pend;
    logic        exc_any;
    logic        take_trap;
    logic        take_mret;
    logic [31:0] cause_d;
    logic [31:0] tval_d;

    // Only the enable bits of interest are consumed; the rest are folded away here.
    logic        unused_bits;
    assign unused_bits = ^{mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0],
                           csr_mstatus_wdata_i[31:13], csr_mstatus_wdata_i[10:8],
                           csr_mstatus_wdata_i[6:4], csr_mstatus_wdata_i[2:0]};

    assign meie_hit  = meip_i & mie_i[11];
    assign msie_hit  = msip_i & mie_i[3];
    assign mtie_hit  = mtip_i & mie_i[7];
    assign int_pend  = mie_q & (meie_hit | msie_hit | mtie_hit);
    assign exc_any   = e_fetch_mis_i | e_illegal_i | e_illegal_csr_i | e_ecall_i |
                       e_ebreak_i | e_load_mis_i | e_store_mis_i;
    assign take_trap = (state == IDLE) & valid_i & (int_pend | exc_any);
    assign take_mret = (state == IDLE) & valid_i & mret_i & ~take_trap;

    assign flush_o       = take_trap;
    assign redirect_pc_o = redirect_o ? exc_ret_addr_i : 32'h0;
    assign mstatus_o     = {19'b0, mpp_q, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
    assign mip_o         = {20'b0, meip_i, 3'b0, mtip_i, 3'b0, msip_i, 3'b0};

    // Cause/tval selection: interrupts first, then exceptions in fixed priority order.
    always_comb begin
        cause_d = 32'h0;
        tval_d  = 32'h0;
        if (int_pend) begin
            if (meie_hit)      cause_d = {1'b1, 27'b0, 4'd11};
            else if (msie_hit) cause_d = {1'b1, 27'b0, 4'd3};
            else               cause_d = {1'b1, 27'b0, 4'd7};
        end else if (e_fetch_mis_i) begin
            cause_d = 32'd0;
            tval_d  = badaddr_i;
        end else if (e_illegal_i | e_illegal_csr_i) begin
            cause_d = 32'd2;
            tval_d  = instr_i;
        end else if (e_ebreak_i) begin
            cause_d = 32'd3;
            tval_d  = pc_i;
        end else if (e_ecall_i) begin
            cause_d = 32'd11;
        end else if (e_load_mis_i) begin
            cause_d = 32'd4;
            tval_d  = badaddr_i;
        end else begin
            cause_d = 32'd6;
            tval_d  = badaddr_i;
        end
    end

    // Sequencer: owns mstatus bits, trap data registers and registered strobes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= IDLE;
            mie_q          <= 1'b0;
            mpie_q         <= 1'b0;
            mpp_q          <= RESET_MPP;
            mcause_o       <= 32'h0;
            mepc_o         <= 32'h0;
            mtval_o        <= 32'h0;
            we_exc_o       <= 1'b0;
            is_int_o       <= 1'b0;
            busy_o         <= 1'b0;
            sel_exc_nret_o <= 1'b0;
            redirect_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_trap) begin
                        mcause_o       <= cause_d;
                        mepc_o         <= pc_i;
                        mtval_o        <= tval_d;
                        mpie_q         <= mie_q;
                        mie_q          <= 1'b0;
                        mpp_q          <= 2'b11;
                        we_exc_o       <= 1'b1;
                        is_int_o       <= int_pend;
                        busy_o         <= 1'b1;
                        sel_exc_nret_o <= 1'b0;
                        state          <= TRAP;
                    end else if (take_mret) begin
                        mie_q          <= mpie_q;
                        mpie_q         <= 1'b1;
                        mpp_q          <= 2'b11;
                        sel_exc_nret_o <= 1'b1;
                        redirect_o     <= 1'b1;
                        busy_o         <= 1'b1;
                        state          <= RET;
                    end else if (csr_mstatus_we_i) begin
                        mie_q  <= csr_mstatus_wdata_i[3];
                        mpie_q <= csr_mstatus_wdata_i[7];
                        mpp_q  <= csr_mstatus_wdata_i[12:11];
                    end
                end
                TRAP: begin
                    we_exc_o   <= 1'b0;
                    is_int_o   <= 1'b0;
                    redirect_o <= 1'b1;
                    state      <= REDIR;
                end
                default: begin
                    // REDIR and RET both finish with a single redirect cycle.
                    redirect_o     <= 1'b0;
                    sel_exc_nret_o <= 1'b0;
                    busy_o         <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule
